// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES-128 inverse cipher, one round per clock.
// Round keys are regenerated backwards from the last round key, so only one
// 128-bit key register is needed.
// Build option: INV_CIPHER_KEY_EXPAND_EN -- when defined, `key` is the original
// cipher key and an EXPAND phase first runs the forward schedule to round 10.
// When undefined, `key` must already be the round-10 key.
// Byte layout: blk[c][r] holds byte 4c+r, so a 128-bit hex literal maps with
// its most significant byte to [0][0].
module inv_cipher (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:3][0:3][7:0] key,
  input  logic [0:3][0:3][7:0] data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [0:3][0:3][7:0] o,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned NR    = 10;
  localparam int unsigned RND_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef INV_CIPHER_KEY_EXPAND_EN
  localparam logic [1:0] S_EXPAND = 2'd1;
`endif
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef logic [0:3][7:0]       word_t;
  typedef logic [0:3][0:3][7:0]  blk_t;

  // GF(2^8) multiply by x, modulus x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) general multiply (shift-and-add)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] m;
    acc = 8'h00;
    m   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ m;
      m = xtime(m);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward S-box: inverse followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by the inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // SubWord(RotWord(w))
  function automatic word_t sub_rot_word(input word_t w);
    word_t r;
    r[0] = sbox(w[1]);
    r[1] = sbox(w[2]);
    r[2] = sbox(w[3]);
    r[3] = sbox(w[0]);
    return r;
  endfunction

  // Round constant for key-schedule round n (1..10)
  function automatic logic [7:0] rcon(input logic [RND_W-1:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // InvMixColumns on a single column
  function automatic word_t inv_mix_col(input word_t a);
    word_t r;
    r[0] = gf_mul(a[0], 8'h0e) ^ gf_mul(a[1], 8'h0b) ^ gf_mul(a[2], 8'h0d) ^ gf_mul(a[3], 8'h09);
    r[1] = gf_mul(a[0], 8'h09) ^ gf_mul(a[1], 8'h0e) ^ gf_mul(a[2], 8'h0b) ^ gf_mul(a[3], 8'h0d);
    r[2] = gf_mul(a[0], 8'h0d) ^ gf_mul(a[1], 8'h09) ^ gf_mul(a[2], 8'h0e) ^ gf_mul(a[3], 8'h0b);
    r[3] = gf_mul(a[0], 8'h0b) ^ gf_mul(a[1], 8'h0d) ^ gf_mul(a[2], 8'h09) ^ gf_mul(a[3], 8'h0e);
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  blk_t             st_q, st_d;
  blk_t             rk_q, rk_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  blk_t             o_q, o_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  word_t            prev3;
  word_t            sw_in;
  word_t            sw_out;
  logic [7:0]       rc;
  blk_t             p;
  blk_t             t;
  blk_t             imc;

  assign prev3 = rk_q[3] ^ rk_q[2];

  // One shared SubWord/RotWord unit: forward schedule in EXPAND, backward in ROUND
`ifdef INV_CIPHER_KEY_EXPAND_EN
  blk_t rk_fwd;

  assign sw_in = (state_q == S_EXPAND) ? rk_q[3] : prev3;
  assign rc    = (state_q == S_EXPAND) ? rcon(rnd_q) : rcon(RND_W'(rnd_q + 4'd1));

  // Forward key-schedule step: round rnd key from round rnd-1 key
  always_comb begin
    rk_fwd    = '0;
    rk_fwd[0] = rk_q[0] ^ sw_out ^ {rc, 24'h000000};
    rk_fwd[1] = rk_q[1] ^ rk_fwd[0];
    rk_fwd[2] = rk_q[2] ^ rk_fwd[1];
    rk_fwd[3] = rk_q[3] ^ rk_fwd[2];
  end
`else
  assign sw_in = prev3;
  assign rc    = rcon(RND_W'(rnd_q + 4'd1));
`endif

  assign sw_out = sub_rot_word(sw_in);

  // Backward key step and one inverse round on the current state
  always_comb begin
    p   = '0;
    t   = '0;
    imc = '0;
    p[3] = prev3;
    p[2] = rk_q[2] ^ rk_q[1];
    p[1] = rk_q[1] ^ rk_q[0];
    p[0] = rk_q[0] ^ sw_out ^ {rc, 24'h000000};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[2'(c)][2'(r)] = inv_sbox(st_q[2'(c - r)][2'(r)]) ^ p[2'(c)][2'(r)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      imc[2'(c)] = inv_mix_col(t[2'(c)]);
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    rnd_d       = rnd_q;
    o_d         = o_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          rk_d    = key;
`ifdef INV_CIPHER_KEY_EXPAND_EN
          st_d    = data;
          rnd_d   = 4'd1;
          state_d = S_EXPAND;
`else
          st_d    = data ^ key;
          rnd_d   = RND_W'(NR - 1);
          state_d = S_ROUND;
`endif
        end
      end
`ifdef INV_CIPHER_KEY_EXPAND_EN
      S_EXPAND: begin
        rk_d = rk_fwd;
        if (rnd_q == RND_W'(NR)) begin
          st_d    = st_q ^ rk_fwd;
          rnd_d   = RND_W'(NR - 1);
          state_d = S_ROUND;
        end else begin
          rnd_d   = RND_W'(rnd_q + 4'd1);
        end
      end
`endif
      S_ROUND: begin
        rk_d = p;
        if (rnd_q == '0) begin
          st_d    = t;
          o_d     = t;
          state_d = S_DONE;
        end else begin
          st_d    = imc;
          rnd_d   = RND_W'(rnd_q - 4'd1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any block in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      st_q        <= '0;
      rk_q        <= '0;
      rnd_q       <= '0;
      o_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      rnd_q       <= rnd_d;
      o_q         <= o_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign o         = o_q;

endmodule

// File: tb/tb_inv_cipher.sv
// tb_inv_cipher: self-checking bench for inv_cipher using FIPS-197 vectors.
// Honours INV_CIPHER_KEY_EXPAND_EN (original key, 20-cycle latency).
module tb_inv_cipher;

  logic                 clk;
  logic                 rst;
  logic [0:3][0:3][7:0] key;
  logic [0:3][0:3][7:0] data;
  logic                 in_valid;
  logic                 in_ready;
  logic [0:3][0:3][7:0] o;
  logic                 out_valid;
  logic                 out_ready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [127:0] exp_q[$];

`ifdef INV_CIPHER_KEY_EXPAND_EN
  localparam int LAT = 20;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
  localparam int LAT = 10;
  localparam logic [127:0] KEY_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  // Accept-to-accept spacing: LAT round cycles, one DONE cycle, one IDLE cycle
  localparam int SPACING = LAT + 2;

  inv_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .data      (data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .o         (o),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Call at a negedge; presents a block and returns at the negedge after accept
  task automatic drive_accept(input logic [127:0] k, input logic [127:0] d,
                              input logic [127:0] pt, output int acc_cyc, output bit to);
    to      = 1'b1;
    acc_cyc = 0;
    key      = k;
    data     = d;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready === 1'b1) begin
        exp_q.push_back(pt);
        @(negedge clk);
        acc_cyc = cyc;
        to      = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Call at a negedge; returns at the first negedge with out_valid high
  task automatic wait_valid(output int v_cyc, output bit to);
    to    = 1'b1;
    v_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid === 1'b1) begin
        v_cyc = cyc;
        to    = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    key       = '0;
    data      = '0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (o !== 128'h0) begin errors++; $display("FAIL reset_o: got %h want 0", o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_c1();
    int acc, vc;
    bit to;
    logic [127:0] exp_v;
    out_ready = 1'b1;
    drive_accept(KEY_C1, CT_C1, PT_C1, acc, to);
    in_valid = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL c1_accept: in_ready never seen"); end
    wait_valid(vc, to);
    checks++;
    if (to) begin errors++; $display("FAIL c1_valid: out_valid timeout"); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL c1_data: got %h, scoreboard empty", o); end
    else begin
      exp_v = exp_q.pop_front();
      if (o !== exp_v) begin errors++; $display("FAIL c1_data: got %h want %h", o, exp_v); end
    end
    checks++;
    if (vc - acc != LAT) begin errors++; $display("FAIL c1_latency: got %0d want %0d", vc - acc, LAT); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL c1_pulse: out_valid got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL c1_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_appb();
    int acc, vc;
    bit to;
    logic [127:0] exp_v;
    out_ready = 1'b1;
    drive_accept(KEY_B, CT_B, PT_B, acc, to);
    in_valid = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL appb_accept: in_ready never seen"); end
    wait_valid(vc, to);
    checks++;
    if (to) begin errors++; $display("FAIL appb_valid: out_valid timeout"); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL appb_data: got %h, scoreboard empty", o); end
    else begin
      exp_v = exp_q.pop_front();
      if (o !== exp_v) begin errors++; $display("FAIL appb_data: got %h want %h", o, exp_v); end
    end
    checks++;
    if (vc - acc != LAT) begin errors++; $display("FAIL appb_latency: got %0d want %0d", vc - acc, LAT); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int acc, vc;
    bit to;
    logic [127:0] exp_v;
    exp_v = PT_C1;
    out_ready = 1'b0;
    drive_accept(KEY_C1, CT_C1, PT_C1, acc, to);
    in_valid = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL bp_accept: in_ready never seen"); end
    wait_valid(vc, to);
    checks++;
    if (to) begin errors++; $display("FAIL bp_valid: out_valid timeout"); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL bp_data: got %h, scoreboard empty", o); end
    else begin
      exp_v = exp_q.pop_front();
      if (o !== exp_v) begin errors++; $display("FAIL bp_data: got %h want %h", o, exp_v); end
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      key      = {$urandom, $urandom, $urandom, $urandom};
      data     = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checks++;
      if (o !== exp_v) begin errors++; $display("FAIL bp_hold_o[%0d]: got %h want %h", i, o, exp_v); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int acc, vc;
    bit to;
    logic [127:0] exp_v;
    out_ready = 1'b1;
    drive_accept(KEY_C1, CT_C1, PT_C1, acc, to);
    in_valid = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL rmid_accept: in_ready never seen"); end
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    checks++;
    if (o !== 128'h0) begin errors++; $display("FAIL rmid_o: got %h want 0", o); end
    @(negedge clk);
    rst = 1'b1;
    drive_accept(KEY_B, CT_B, PT_B, acc, to);
    in_valid = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL rmid_reaccept: in_ready never seen"); end
    wait_valid(vc, to);
    checks++;
    if (to) begin errors++; $display("FAIL rmid_valid: out_valid timeout"); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL rmid_data: got %h, scoreboard empty", o); end
    else begin
      exp_v = exp_q.pop_front();
      if (o !== exp_v) begin errors++; $display("FAIL rmid_data: got %h want %h", o, exp_v); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int acc_a, acc_b, vc;
    bit to;
    logic [127:0] exp_v;
    out_ready = 1'b1;
    drive_accept(KEY_C1, CT_C1, PT_C1, acc_a, to);
    checks++;
    if (to) begin errors++; $display("FAIL b2b_accept_a: in_ready never seen"); end
    key  = KEY_B;
    data = CT_B;
    wait_valid(vc, to);
    checks++;
    if (to) begin errors++; $display("FAIL b2b_valid_a: out_valid timeout"); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_data_a: got %h, scoreboard empty", o); end
    else begin
      exp_v = exp_q.pop_front();
      if (o !== exp_v) begin errors++; $display("FAIL b2b_data_a: got %h want %h", o, exp_v); end
    end
    drive_accept(KEY_B, CT_B, PT_B, acc_b, to);
    in_valid = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL b2b_accept_b: in_ready never seen"); end
    checks++;
    if (acc_b - acc_a != SPACING) begin
      errors++; $display("FAIL b2b_spacing: got %0d want %0d", acc_b - acc_a, SPACING);
    end
    wait_valid(vc, to);
    checks++;
    if (to) begin errors++; $display("FAIL b2b_valid_b: out_valid timeout"); end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_data_b: got %h, scoreboard empty", o); end
    else begin
      exp_v = exp_q.pop_front();
      if (o !== exp_v) begin errors++; $display("FAIL b2b_data_b: got %h want %h", o, exp_v); end
    end
    checks++;
    if (vc - acc_b != LAT) begin errors++; $display("FAIL b2b_latency_b: got %0d want %0d", vc - acc_b, LAT); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_c1();
    test_appb();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
